// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin per-message arbiter for the shared UART transmitter
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int DATA_W       = 8,
  parameter int HOLD_TIMEOUT = 1_000_000,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W       = $clog2(HOLD_TIMEOUT) + 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic                      tx_start_o,
  output logic [DATA_W-1:0]         tx_data_o,
  input  logic                      tx_busy_i,
  input  logic                      tx_done_i,
  output logic [ID_W-1:0]           grant_id_o,
  output logic                      locked_o,
  output logic                      timeout_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               terr_q, terr_d;

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    sel_idx;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_last;
  logic [ID_W-1:0]    next_ptr;

  // Round-robin search: first set req starting at rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && req_i[j]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(j);
      end
    end
  end

  // Byte/last selection: the new winner in IDLE, the current owner while holding.
  always_comb begin
    sel_idx  = (state_q == S_HOLD) ? grant_q : win_idx;
    sel_data = req_data_i[int'(sel_idx)*DATA_W +: DATA_W];
    sel_last = req_last_i[sel_idx];
    next_ptr = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  end

  // Next-state logic: message lock, hold timeout and pointer advance on release.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (win_found && !tx_busy_i) begin
          grant_d = win_idx;
          data_d  = sel_data;
          last_d  = sel_last;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (tx_done_i) begin
          if (last_q) begin
            rr_d    = next_ptr;
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (req_i[grant_q] && !tx_busy_i) begin
          data_d  = sel_data;
          last_d  = sel_last;
          state_d = S_LAUNCH;
        end else if (cnt_q >= CNT_W'(HOLD_TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          rr_d    = next_ptr;
          state_d = S_IDLE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // Outputs decoded from state; start and ack exist only in LAUNCH.
  always_comb begin
    tx_start_o    = (state_q == S_LAUNCH);
    ack_o         = (state_q == S_LAUNCH) ? (NUM_REQ'(1) << grant_q) : '0;
    tx_data_o     = data_q;
    grant_id_o    = grant_q;
    locked_o      = (state_q != S_IDLE);
    timeout_err_o = terr_q;
  end

endmodule
